// File: rtl/weight_bias_loader.sv
// weight_bias_loader
//   Transmit side of the neuron weight/bias load bus. Takes one flat 32-bit
//   parameter stream for a layer (valid/ready) and replays it onto the shared
//   broadcast bus as, per neuron, num_weights weight beats followed by one
//   bias beat. Each beat carries layer/neuron tags so exactly one neuron
//   captures it. One run per accepted start pulse.
//
// Ports
//   clk, rst            clock (rising edge), async active-low reset
//   start               run request, sampled only when idle
//   layer_num           layer tag for the run (captured on start)
//   num_neurons         neurons to load (captured on start)
//   num_weights         weights per neuron (captured on start)
//   s_data/s_valid      parameter stream in
//   s_ready             loader accepts a beat this cycle (combinational)
//   weightValid/Value   weight beat on the bus
//   biasValid/Value     bias beat on the bus
//   config_layer_num    destination layer tag
//   config_neuron_num   destination neuron index (zero-extended)
//   busy                run in progress
//   done                one-cycle pulse at the end of a run
module weight_bias_loader #(
    parameter int maxWeights = 784,
    parameter int maxNeurons = 30,
    localparam int wCntWidth = $clog2(maxWeights + 1),
    localparam int nCntWidth = $clog2(maxNeurons + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          layer_num,
    input  logic [nCntWidth-1:0] num_neurons,
    input  logic [wCntWidth-1:0] num_weights,
    input  logic [31:0]          s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 weightValid,
    output logic                 biasValid,
    output logic [31:0]          weightValue,
    output logic [31:0]          biasValue,
    output logic [31:0]          config_layer_num,
    output logic [31:0]          config_neuron_num,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, FINISH} state_t;

    state_t               state, state_nxt;
    logic [31:0]          layer_r;
    logic [nCntWidth-1:0] num_n_r, n_idx;
    logic [wCntWidth-1:0] num_w_r, w_idx;
    logic                 xfer, w_last, n_last;

    assign s_ready = (state == WEIGHT) || (state == BIAS);
    assign xfer    = s_valid && s_ready;
    assign w_last  = (w_idx == num_w_r - wCntWidth'(1));
    assign n_last  = (n_idx == num_n_r - nCntWidth'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // Empty layer: nothing to stream, just report completion.
                    if (num_neurons == '0 || num_weights == '0) state_nxt = FINISH;
                    else                                         state_nxt = WEIGHT;
                end
            end
            WEIGHT: if (xfer && w_last) state_nxt = BIAS;
            BIAS:   if (xfer)           state_nxt = n_last ? FINISH : WEIGHT;
            FINISH:                     state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            layer_r           <= '0;
            num_n_r           <= '0;
            num_w_r           <= '0;
            n_idx             <= '0;
            w_idx             <= '0;
            weightValid       <= 1'b0;
            biasValid         <= 1'b0;
            weightValue       <= '0;
            biasValue         <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            // Valid strobes are single-beat; data and tags hold otherwise.
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            done        <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        layer_r <= layer_num;
                        num_n_r <= num_neurons;
                        num_w_r <= num_weights;
                        n_idx   <= '0;
                        w_idx   <= '0;
                        busy    <= 1'b1;
                    end
                end
                WEIGHT: begin
                    if (xfer) begin
                        weightValid       <= 1'b1;
                        weightValue       <= s_data;
                        config_layer_num  <= layer_r;
                        config_neuron_num <= 32'(n_idx);
                        w_idx             <= w_last ? '0 : w_idx + wCntWidth'(1);
                    end
                end
                BIAS: begin
                    if (xfer) begin
                        biasValid         <= 1'b1;
                        biasValue         <= s_data;
                        config_layer_num  <= layer_r;
                        config_neuron_num <= 32'(n_idx);
                        if (!n_last) n_idx <= n_idx + nCntWidth'(1);
                    end
                end
                FINISH: busy <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/weight_bias_loader.md
Name: weight_bias_loader

Overview:
- Transmit side of the neuron weight/bias load interface.
- Accepts one flat 32-bit stream of pre-trained parameters for one layer (handshaked with valid/ready) and replays it onto the broadcast load bus shared by every neuron in the network.
- Per neuron, in order: numWeight weight beats, then 1 bias beat, each tagged with config_layer_num/config_neuron_num so exactly one neuron captures it.
- Sits between the host/DMA parameter source and the layer instances; one run per start pulse.

Parameters:
- maxWeights, 784, largest weights-per-neuron supported; sets weight counter width wCntWidth = $clog2(maxWeights+1).
- maxNeurons, 30, largest neurons-per-layer supported; sets neuron counter width nCntWidth = $clog2(maxNeurons+1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle run request; sampled only in IDLE.
- layer_num  in  32  layer tag for this run; captured on accepted start.
- num_neurons  in  nCntWidth  neurons to load; captured on accepted start.
- num_weights  in  wCntWidth  weights per neuron; captured on accepted start.
- s_data  in  32  parameter stream data.
- s_valid  in  1  stream data valid.
- s_ready  out  1  loader can accept a beat.
- weightValid  out  1  weight beat on bus.
- biasValid  out  1  bias beat on bus.
- weightValue  out  32  weight data.
- biasValue  out  32  bias data.
- config_layer_num  out  32  destination layer tag.
- config_neuron_num  out  32  destination neuron index, zero-extended.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when the run completes.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; counters clear.
  - All outputs go to 0: s_ready, weightValid, biasValid, weightValue, biasValue, config_*, busy, done.
- FSM states: IDLE, WEIGHT, BIAS, FINISH.
- IDLE:
  - On start=1: capture layer_num, num_neurons, num_weights; clear nIdx and wIdx; busy<=1.
  - If num_neurons==0 or num_weights==0: go to FINISH; no beats consumed.
  - Otherwise go to WEIGHT.
- s_ready is combinational: 1 exactly in WEIGHT or BIAS. A beat transfers when s_valid & s_ready.
- WEIGHT, per transfer:
  - Next edge: weightValid<=1, weightValue<=s_data, config_neuron_num<=nIdx, config_layer_num<=captured layer.
  - wIdx increments.
  - When wIdx==num_weights-1 on the transfer: wIdx<=0 and go to BIAS.
- BIAS, per transfer:
  - Next edge: biasValid<=1, biasValue<=s_data, config tags as above.
  - If nIdx==num_neurons-1: go to FINISH; otherwise nIdx increments and go to WEIGHT.
- Any cycle without a transfer: weightValid and biasValid are 0 next cycle. weightValue, biasValue and config_* hold their last values.
- Latency: exactly 1 cycle from stream transfer to bus beat. Throughput 1 beat/cycle with no bubbles between neurons or between weight and bias.
- Exactly one of weightValid/biasValid is high per bus beat, never both.
- Each neuron receives exactly num_weights contiguous weightValid beats before its biasValid. Neurons pre-increment their write address per beat, so the count must be exact.
- FINISH: done<=1 and busy<=0 for one cycle, after the final bias beat has been issued (same cycle as or after it); then go to IDLE.
- start while busy is ignored; captured values do not change mid-run.
- s_valid dropping mid-run stalls the FSM indefinitely with counters held; no timeout.
- Counters never wrap; inputs above maxWeights/maxNeurons are out of contract.

Test Plan:
- start, layer_num=1, num_neurons=2, num_weights=3, stream 0x10..0x17 with s_valid held high -> weightValid on 0x10,0x11,0x12 (neuron 0), biasValid 0x13 (neuron 0), weights 0x14..0x16 and bias 0x17 (neuron 1); 8 consecutive bus cycles; done 1 cycle after the last beat.
- Same run with s_valid toggling 1/0 every cycle -> identical bus sequence and tags with 1-cycle gaps; no beat lost or duplicated.
- num_weights=0, num_neurons=4 -> s_ready stays 0; done pulses 2 cycles after start; no valid beats.
- start pulsed again during the run with layer_num=2 -> ignored; all beats keep tag 1; exactly one done.
- rst low mid-way through neuron 1's weights -> all outputs 0 asynchronously; after release a fresh start reloads from neuron 0, wIdx 0.
- num_neurons=maxNeurons, num_weights=maxWeights, continuous stream -> last beat is biasValid with config_neuron_num=29; total beats 30*785=23550.
